// File: rtl/ram2_loader.sv
// ram2_loader: writer side of the Ram2 instruction memory.
// Takes a little-endian byte stream (16-bit word count, then the words)
// from the serial receiver and writes every word into Ram2 with an explicit
// SETUP / WE pulse / HOLD sequence. The CPU is held until the image is in.
// All outputs come from registers, so Ram2 control lines and CpuHold/Done
// are glitch-free and change together on state transitions.

module ram2_loader #(
    parameter logic [17:0] LOAD_BASE = 18'h00000,
    parameter int unsigned WE_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    output logic        Ram2_EN,
    output logic        Ram2_OE,
    output logic        Ram2_WE,
    output logic [17:0] Ram2_address,
    inout  wire  [15:0] Ram2_data,
    output logic        CpuHold,
    output logic        Done,
    output logic        Overrun
);

    typedef enum logic [2:0] {
        LEN_LO  = 3'd0,
        LEN_HI  = 3'd1,
        DATA_LO = 3'd2,
        DATA_HI = 3'd3,
        SETUP   = 3'd4,
        WPULSE  = 3'd5,
        HOLD    = 3'd6,
        DONE    = 3'd7
    } loadState_t;

    // Pulse counter preload: WE stays low while the counter runs down to zero.
    localparam logic [3:0] WE_PRELOAD = 4'(WE_CYCLES - 1);

    loadState_t  state_r;
    logic [15:0] len_r;
    logic [15:0] wordIdx_r;
    logic [15:0] word_r;
    logic [3:0]  weCount_r;
    logic [17:0] addr_r;
    logic        drive_r;
    logic        rxReady_r;
    logic        en_r;
    logic        oe_r;
    logic        we_r;
    logic        cpuHold_r;
    logic        done_r;
    logic        overrun_r;

    logic        acceptByte_s;
    logic        dropByte_s;
    logic [16:0] nextIdx_s;
    logic        lastWord_s;
    logic [17:0] writeAddr_s;
    logic [15:0] fullLen_s;

    assign acceptByte_s = RxValid & rxReady_r;
    assign dropByte_s   = RxValid & ~rxReady_r;
    // 17 bits so the compare against a 65535-word length cannot wrap.
    assign nextIdx_s    = {1'b0, wordIdx_r} + 17'd1;
    assign lastWord_s   = (nextIdx_s == {1'b0, len_r});
    // Address wraps naturally at 2^18 through truncation.
    assign writeAddr_s  = LOAD_BASE + {2'b00, wordIdx_r};
    assign fullLen_s    = {RxData, len_r[7:0]};

    assign RxReady      = rxReady_r;
    assign Ram2_EN      = en_r;
    assign Ram2_OE      = oe_r;
    assign Ram2_WE      = we_r;
    assign Ram2_address = addr_r;
    assign Ram2_data    = drive_r ? word_r : 16'hzzzz;
    assign CpuHold      = cpuHold_r;
    assign Done         = done_r;
    assign Overrun      = overrun_r;

    // Load sequencer: stream parsing, Ram2 write timing and all registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r   <= LEN_LO;
            len_r     <= 16'd0;
            wordIdx_r <= 16'd0;
            word_r    <= 16'd0;
            weCount_r <= 4'd0;
            addr_r    <= LOAD_BASE;
            drive_r   <= 1'b0;
            rxReady_r <= 1'b1;
            en_r      <= 1'b1;
            oe_r      <= 1'b1;
            we_r      <= 1'b1;
            cpuHold_r <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            // The loader never reads Ram2.
            oe_r <= 1'b1;
            case (state_r)
                LEN_LO: begin
                    if (acceptByte_s) begin
                        len_r[7:0] <= RxData;
                        state_r    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (acceptByte_s) begin
                        len_r[15:8] <= RxData;
                        if (fullLen_s == 16'd0) begin
                            // Empty image: release the CPU straight away.
                            state_r   <= DONE;
                            rxReady_r <= 1'b0;
                            cpuHold_r <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            state_r <= DATA_LO;
                        end
                    end
                end
                DATA_LO: begin
                    if (acceptByte_s) begin
                        word_r[7:0] <= RxData;
                        state_r     <= DATA_HI;
                    end
                end
                DATA_HI: begin
                    if (acceptByte_s) begin
                        // Word complete: enable chip, present address and data.
                        word_r[15:8] <= RxData;
                        state_r      <= SETUP;
                        rxReady_r    <= 1'b0;
                        en_r         <= 1'b0;
                        drive_r      <= 1'b1;
                        addr_r       <= writeAddr_s;
                    end
                end
                SETUP: begin
                    state_r   <= WPULSE;
                    we_r      <= 1'b0;
                    weCount_r <= WE_PRELOAD;
                end
                WPULSE: begin
                    if (weCount_r == 4'd0) begin
                        state_r <= HOLD;
                        we_r    <= 1'b1;
                    end else begin
                        weCount_r <= weCount_r - 4'd1;
                    end
                end
                HOLD: begin
                    // Address/data were held through this cycle; release the bus.
                    wordIdx_r <= nextIdx_s[15:0];
                    en_r      <= 1'b1;
                    drive_r   <= 1'b0;
                    if (lastWord_s) begin
                        state_r   <= DONE;
                        cpuHold_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else begin
                        state_r   <= DATA_LO;
                        rxReady_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r   <= DONE;
                    rxReady_r <= 1'b0;
                    en_r      <= 1'b1;
                    we_r      <= 1'b1;
                    drive_r   <= 1'b0;
                    cpuHold_r <= 1'b0;
                    done_r    <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: return to a safe idle bus and restart.
                    state_r   <= LEN_LO;
                    rxReady_r <= 1'b1;
                    en_r      <= 1'b1;
                    we_r      <= 1'b1;
                    drive_r   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for bytes that arrived while the loader could not take them.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            overrun_r <= 1'b0;
        end else if (dropByte_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

endmodule

// File: tb/tb_ram2_loader.sv
// Directed bench for ram2_loader: two instances (base 0 and base 3FFFF),
// a bus monitor that logs every Ram2 write window, and immediate assertions.

module tb_ram2_loader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [7:0]  RxData = 8'h00;
    logic        rxValid0 = 1'b0;
    logic        rxValid1 = 1'b0;

    logic        rxReady0, en0, oe0, we0, cpuHold0, done0, overrun0;
    logic [17:0] addr0;
    wire  [15:0] data0;
    logic        rxReady1, en1, oe1, we1, cpuHold1, done1, overrun1;
    logic [17:0] addr1;
    wire  [15:0] data1;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    // Released buses read back as all ones.
    for (genvar i = 0; i < 16; i++) begin : g_pull
        pullup pu0 (data0[i]);
        pullup pu1 (data1[i]);
    end

    ram2_loader #(.LOAD_BASE(18'h00000), .WE_CYCLES(2)) dut0 (
        .Clk(Clk), .Rst(Rst), .RxData(RxData), .RxValid(rxValid0), .RxReady(rxReady0),
        .Ram2_EN(en0), .Ram2_OE(oe0), .Ram2_WE(we0), .Ram2_address(addr0),
        .Ram2_data(data0), .CpuHold(cpuHold0), .Done(done0), .Overrun(overrun0)
    );

    ram2_loader #(.LOAD_BASE(18'h3FFFF), .WE_CYCLES(2)) dut1 (
        .Clk(Clk), .Rst(Rst), .RxData(RxData), .RxValid(rxValid1), .RxReady(rxReady1),
        .Ram2_EN(en1), .Ram2_OE(oe1), .Ram2_WE(we1), .Ram2_address(addr1),
        .Ram2_data(data1), .CpuHold(cpuHold1), .Done(done1), .Overrun(overrun1)
    );

    // Write log for dut0: one entry per EN-low window.
    logic [17:0] logAddr0 [32];
    logic [15:0] logData0 [32];
    int          logEn0 [32];
    int          logWe0 [32];
    logic        logStable0 [32];
    logic        logOeOk0 [32];
    int          wrN0 = 0;
    logic        prevEn0 = 1'b1;
    logic [17:0] capA0 = 18'd0;
    logic [15:0] capD0 = 16'd0;
    int          enCnt0 = 0;
    int          weCnt0 = 0;
    logic        stable0 = 1'b1;
    logic        oeOk0 = 1'b1;

    // Monitor dut0 bus on falling edges: capture window, count EN/WE low cycles, log on EN rise.
    always @(negedge Clk) begin
        prevEn0 <= en0;
        if (en0 == 1'b0) begin
            if (prevEn0) begin
                capA0   <= addr0;
                capD0   <= data0;
                enCnt0  <= 1;
                weCnt0  <= (we0 == 1'b0) ? 1 : 0;
                stable0 <= 1'b1;
                oeOk0   <= oe0;
            end else begin
                enCnt0 <= enCnt0 + 1;
                if (we0 == 1'b0) weCnt0 <= weCnt0 + 1;
                if (addr0 !== capA0 || data0 !== capD0) stable0 <= 1'b0;
                if (oe0 !== 1'b1) oeOk0 <= 1'b0;
            end
        end else if (!prevEn0 && wrN0 < 32) begin
            logAddr0[wrN0]   <= capA0;
            logData0[wrN0]   <= capD0;
            logEn0[wrN0]     <= enCnt0;
            logWe0[wrN0]     <= weCnt0;
            logStable0[wrN0] <= stable0;
            logOeOk0[wrN0]   <= oeOk0;
            wrN0             <= wrN0 + 1;
        end
    end

    // Write log for dut1: address/data at the start of each EN-low window.
    logic [17:0] logAddr1 [8];
    logic [15:0] logData1 [8];
    int          wrN1 = 0;
    logic        prevEn1 = 1'b1;

    // Monitor dut1 bus on falling edges.
    always @(negedge Clk) begin
        prevEn1 <= en1;
        if (en1 == 1'b0 && prevEn1 && wrN1 < 8) begin
            logAddr1[wrN1] <= addr1;
            logData1[wrN1] <= data1;
            wrN1           <= wrN1 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input bit which, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge Clk);
        while ((which ? rxReady1 : rxReady0) !== 1'b1 && n < 64) begin
            @(negedge Clk);
            n++;
        end
        check("rxready wait", {31'd0, (which ? rxReady1 : rxReady0)}, 32'd1);
        RxData = b;
        if (which) rxValid1 = 1'b1;
        else       rxValid0 = 1'b1;
        @(posedge Clk);
        #1;
        rxValid0 = 1'b0;
        rxValid1 = 1'b0;
    endtask

    task automatic waitDone(input bit which);
        int n;
        n = 0;
        @(negedge Clk);
        while ((which ? done1 : done0) !== 1'b1 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check("done reached", {31'd0, (which ? done1 : done0)}, 32'd1);
        @(negedge Clk);
        #1;
    endtask

    task automatic pulseReset();
        Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        #1;
    endtask

    int base;

    initial begin
        // Reset state
        @(negedge Clk);
        @(negedge Clk);
        check("rst EN", {31'd0, en0}, 32'd1);
        check("rst OE", {31'd0, oe0}, 32'd1);
        check("rst WE", {31'd0, we0}, 32'd1);
        check("rst addr", {14'd0, addr0}, 32'h00000);
        check("rst addr base1", {14'd0, addr1}, 32'h3FFFF);
        check("rst data released", {16'd0, data0}, 32'hFFFF);
        check("rst RxReady", {31'd0, rxReady0}, 32'd1);
        check("rst CpuHold", {31'd0, cpuHold0}, 32'd1);
        check("rst Done", {31'd0, done0}, 32'd0);
        check("rst Overrun", {31'd0, overrun0}, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);
        #1;

        // Three-word image into base 0
        base = wrN0;
        sendByte(1'b0, 8'h03); sendByte(1'b0, 8'h00);
        check("hold during load", {31'd0, cpuHold0}, 32'd1);
        sendByte(1'b0, 8'h34); sendByte(1'b0, 8'h12);
        sendByte(1'b0, 8'h78); sendByte(1'b0, 8'h56);
        sendByte(1'b0, 8'hBC); sendByte(1'b0, 8'h9A);
        waitDone(1'b0);
        check("t1 write count", wrN0 - base, 32'd3);
        check("t1 w0 addr", {14'd0, logAddr0[base]}, 32'h00000);
        check("t1 w0 data", {16'd0, logData0[base]}, 32'h1234);
        check("t1 w1 addr", {14'd0, logAddr0[base+1]}, 32'h00001);
        check("t1 w1 data", {16'd0, logData0[base+1]}, 32'h5678);
        check("t1 w2 addr", {14'd0, logAddr0[base+2]}, 32'h00002);
        check("t1 w2 data", {16'd0, logData0[base+2]}, 32'h9ABC);
        for (int k = 0; k < 3; k++) begin
            check("t2 WE low cycles", logWe0[base+k], 32'd2);
            check("t2 EN low cycles", logEn0[base+k], 32'd4);
            check("t2 addr/data stable", {31'd0, logStable0[base+k]}, 32'd1);
            check("t2 OE high", {31'd0, logOeOk0[base+k]}, 32'd1);
        end
        check("t1 CpuHold", {31'd0, cpuHold0}, 32'd0);
        check("t1 RxReady", {31'd0, rxReady0}, 32'd0);
        check("t1 EN idle", {31'd0, en0}, 32'd1);
        check("t1 data released", {16'd0, data0}, 32'hFFFF);
        check("t1 Overrun", {31'd0, overrun0}, 32'd0);

        // Wrapping base on the second instance
        sendByte(1'b1, 8'h02); sendByte(1'b1, 8'h00);
        sendByte(1'b1, 8'h01); sendByte(1'b1, 8'h00);
        sendByte(1'b1, 8'h02); sendByte(1'b1, 8'h00);
        waitDone(1'b1);
        check("t5 write count", wrN1, 32'd2);
        check("t5 w0 addr", {14'd0, logAddr1[0]}, 32'h3FFFF);
        check("t5 w0 data", {16'd0, logData1[0]}, 32'h0001);
        check("t5 w1 addr", {14'd0, logAddr1[1]}, 32'h00000);
        check("t5 w1 data", {16'd0, logData1[1]}, 32'h0002);
        check("t5 CpuHold", {31'd0, cpuHold1}, 32'd0);

        // Zero-length image
        pulseReset();
        check("t3 Done cleared", {31'd0, done0}, 32'd0);
        base = wrN0;
        sendByte(1'b0, 8'h00); sendByte(1'b0, 8'h00);
        check("t3 Done at once", {31'd0, done0}, 32'd1);
        check("t3 CpuHold at once", {31'd0, cpuHold0}, 32'd0);
        check("t3 RxReady", {31'd0, rxReady0}, 32'd0);
        repeat (5) @(negedge Clk);
        #1;
        check("t3 no writes", wrN0 - base, 32'd0);
        check("t3 EN idle", {31'd0, en0}, 32'd1);

        // Byte strobed during the WE pulse is dropped
        pulseReset();
        base = wrN0;
        sendByte(1'b0, 8'h02); sendByte(1'b0, 8'h00);
        sendByte(1'b0, 8'h11); sendByte(1'b0, 8'h11);
        @(posedge Clk);
        #1;
        check("t4 in WE pulse", {31'd0, we0}, 32'd0);
        check("t4 RxReady low", {31'd0, rxReady0}, 32'd0);
        RxData   = 8'hEE;
        rxValid0 = 1'b1;
        @(posedge Clk);
        #1;
        rxValid0 = 1'b0;
        check("t4 Overrun set", {31'd0, overrun0}, 32'd1);
        sendByte(1'b0, 8'h22); sendByte(1'b0, 8'h22);
        waitDone(1'b0);
        check("t4 write count", wrN0 - base, 32'd2);
        check("t4 w0 data", {16'd0, logData0[base]}, 32'h1111);
        check("t4 w1 addr", {14'd0, logAddr0[base+1]}, 32'h00001);
        check("t4 w1 data", {16'd0, logData0[base+1]}, 32'h2222);
        check("t4 Overrun sticky", {31'd0, overrun0}, 32'd1);

        // Reset in the middle of the second word's WE pulse, then reload
        pulseReset();
        check("t6 Overrun cleared", {31'd0, overrun0}, 32'd0);
        sendByte(1'b0, 8'h02); sendByte(1'b0, 8'h00);
        sendByte(1'b0, 8'hAA); sendByte(1'b0, 8'h55);
        sendByte(1'b0, 8'hCC); sendByte(1'b0, 8'h33);
        @(posedge Clk);
        #1;
        check("t6 in WE pulse", {31'd0, we0}, 32'd0);
        Rst = 1'b1;
        #1;
        check("t6 async WE", {31'd0, we0}, 32'd1);
        check("t6 async EN", {31'd0, en0}, 32'd1);
        check("t6 async data", {16'd0, data0}, 32'hFFFF);
        check("t6 CpuHold", {31'd0, cpuHold0}, 32'd1);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        #1;
        base = wrN0;
        sendByte(1'b0, 8'h02); sendByte(1'b0, 8'h00);
        sendByte(1'b0, 8'hAA); sendByte(1'b0, 8'h55);
        sendByte(1'b0, 8'hCC); sendByte(1'b0, 8'h33);
        waitDone(1'b0);
        check("t6 write count", wrN0 - base, 32'd2);
        check("t6 w0 addr", {14'd0, logAddr0[base]}, 32'h00000);
        check("t6 w0 data", {16'd0, logData0[base]}, 32'h55AA);
        check("t6 w1 addr", {14'd0, logAddr0[base+1]}, 32'h00001);
        check("t6 w1 data", {16'd0, logData0[base+1]}, 32'h33CC);
        check("t6 CpuHold", {31'd0, cpuHold0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
